// File: rtl/sd_spi_block_read_if.sv
// Bus bundle between an SD-card single-sector reader and its requester/card side.
interface sd_spi_block_read_if;
    logic        miso;
    logic        rd_en;
    logic [31:0] rd_addr;
    logic        cs_n;
    logic        mosi;
    logic        rd_busy;
    logic        rd_data_en;
    logic [15:0] rd_data;
    logic        rd_err;

    // Reader side: takes requests and card data, drives the card and the payload stream.
    modport slave (
        input  miso,
        input  rd_en,
        input  rd_addr,
        output cs_n,
        output mosi,
        output rd_busy,
        output rd_data_en,
        output rd_data,
        output rd_err
    );

    // Requester/card side.
    modport master (
        output miso,
        output rd_en,
        output rd_addr,
        input  cs_n,
        input  mosi,
        input  rd_busy,
        input  rd_data_en,
        input  rd_data,
        input  rd_err
    );
endinterface

// File: rtl/sd_spi_block_read.sv
// SPI-mode SD single-sector reader: CMD17, R1, start token, 256 x 16-bit words, CRC discard.
module sd_spi_block_read #(
    parameter logic [7:0]  CMD_IDX       = 8'h51,
    parameter int unsigned R1_TIMEOUT    = 64,
    parameter int unsigned TOKEN_TIMEOUT = 65535
) (
    input  logic                 sys_clk,
    input  logic                 sys_rst,
    sd_spi_block_read_if.slave   sd
);
    localparam int unsigned FRAME_W = 48;
    localparam int unsigned WORD_W  = 16;

    typedef enum logic [2:0] {
        S_IDLE,
        S_CMD,
        S_WAIT_R1,
        S_WAIT_TOKEN,
        S_DATA,
        S_CRC,
        S_END
    } state_t;

    state_t              state_q, state_d;
    logic [31:0]         addr_q, addr_d;
    logic [5:0]          cmd_cnt_q, cmd_cnt_d;
    logic [11:0]         bit_cnt_q, bit_cnt_d;
    logic [15:0]         wait_cnt_q, wait_cnt_d;
    logic                r1_active_q, r1_active_d;
    logic [2:0]          r1_bits_q, r1_bits_d;
    // Shift histories hold all but the newest bit; the newest is miso itself.
    logic [6:0]          r1_sr_q, r1_sr_d;
    logic [6:0]          tok_sr_q, tok_sr_d;
    logic [WORD_W-2:0]   data_sr_q, data_sr_d;
    logic                cs_n_q, cs_n_d;
    logic                mosi_q, mosi_d;
    logic                busy_q, busy_d;
    logic [WORD_W-1:0]   rd_data_q, rd_data_d;
    logic                rd_data_en_q, rd_data_en_d;
    logic                rd_err_q, rd_err_d;

    logic [FRAME_W-1:0]  frame_c;
    logic [7:0]          r1_byte_c;
    logic [7:0]          tok_byte_c;
    logic [WORD_W-1:0]   word_c;

    // State and output registers.
    always_ff @(posedge sys_clk or posedge sys_rst) begin
        if (sys_rst) begin
            state_q      <= S_IDLE;
            addr_q       <= '0;
            cmd_cnt_q    <= '0;
            bit_cnt_q    <= '0;
            wait_cnt_q   <= '0;
            r1_active_q  <= 1'b0;
            r1_bits_q    <= '0;
            r1_sr_q      <= '1;
            tok_sr_q     <= '1;
            data_sr_q    <= '0;
            cs_n_q       <= 1'b1;
            mosi_q       <= 1'b1;
            busy_q       <= 1'b0;
            rd_data_q    <= '0;
            rd_data_en_q <= 1'b0;
            rd_err_q     <= 1'b0;
        end else begin
            state_q      <= state_d;
            addr_q       <= addr_d;
            cmd_cnt_q    <= cmd_cnt_d;
            bit_cnt_q    <= bit_cnt_d;
            wait_cnt_q   <= wait_cnt_d;
            r1_active_q  <= r1_active_d;
            r1_bits_q    <= r1_bits_d;
            r1_sr_q      <= r1_sr_d;
            tok_sr_q     <= tok_sr_d;
            data_sr_q    <= data_sr_d;
            cs_n_q       <= cs_n_d;
            mosi_q       <= mosi_d;
            busy_q       <= busy_d;
            rd_data_q    <= rd_data_d;
            rd_data_en_q <= rd_data_en_d;
            rd_err_q     <= rd_err_d;
        end
    end

    // Next-state and registered-output logic for the read transaction.
    always_comb begin
        state_d      = state_q;
        addr_d       = addr_q;
        cmd_cnt_d    = cmd_cnt_q;
        bit_cnt_d    = bit_cnt_q;
        wait_cnt_d   = wait_cnt_q;
        r1_active_d  = r1_active_q;
        r1_bits_d    = r1_bits_q;
        r1_sr_d      = r1_sr_q;
        tok_sr_d     = tok_sr_q;
        data_sr_d    = data_sr_q;
        cs_n_d       = cs_n_q;
        mosi_d       = mosi_q;
        busy_d       = busy_q;
        rd_data_d    = rd_data_q;
        rd_data_en_d = 1'b0;
        rd_err_d     = 1'b0;

        frame_c    = {CMD_IDX, addr_q, 8'hFF};
        r1_byte_c  = {r1_sr_q, sd.miso};
        tok_byte_c = {tok_sr_q, sd.miso};
        word_c     = {data_sr_q, sd.miso};

        unique case (state_q)
            S_IDLE: begin
                cs_n_d = 1'b1;
                mosi_d = 1'b1;
                busy_d = 1'b0;
                if (sd.rd_en) begin
                    addr_d    = sd.rd_addr;
                    cmd_cnt_d = '0;
                    cs_n_d    = 1'b0;
                    busy_d    = 1'b1;
                    mosi_d    = CMD_IDX[7];
                    state_d   = S_CMD;
                end
            end

            // mosi already shows frame bit cmd_cnt_q; queue up the following one.
            S_CMD: begin
                if (cmd_cnt_q == 6'd47) begin
                    mosi_d      = 1'b1;
                    wait_cnt_d  = '0;
                    r1_active_d = 1'b0;
                    r1_bits_d   = '0;
                    state_d     = S_WAIT_R1;
                end else begin
                    cmd_cnt_d = cmd_cnt_q + 6'd1;
                    mosi_d    = frame_c[6'd46 - cmd_cnt_q];
                end
            end

            S_WAIT_R1: begin
                mosi_d = 1'b1;
                if (!r1_active_q) begin
                    if (!sd.miso) begin
                        r1_active_d = 1'b1;
                        r1_bits_d   = 3'd1;
                        r1_sr_d     = '0;
                    end else if (wait_cnt_q == 16'(R1_TIMEOUT - 1)) begin
                        cs_n_d    = 1'b1;
                        bit_cnt_d = '0;
                        rd_err_d  = 1'b1;
                        state_d   = S_END;
                    end else begin
                        wait_cnt_d = wait_cnt_q + 16'd1;
                    end
                end else begin
                    r1_sr_d = r1_byte_c[6:0];
                    if (r1_bits_q == 3'd7) begin
                        if (r1_byte_c == 8'h00) begin
                            tok_sr_d   = '1;
                            wait_cnt_d = '0;
                            state_d    = S_WAIT_TOKEN;
                        end else begin
                            cs_n_d    = 1'b1;
                            bit_cnt_d = '0;
                            rd_err_d  = 1'b1;
                            state_d   = S_END;
                        end
                    end else begin
                        r1_bits_d = r1_bits_q + 3'd1;
                    end
                end
            end

            // Moving to DATA on the edge that completes 0xFE makes the next edge sample payload bit 0.
            S_WAIT_TOKEN: begin
                mosi_d   = 1'b1;
                tok_sr_d = tok_byte_c[6:0];
                if (tok_byte_c == 8'hFE) begin
                    bit_cnt_d = '0;
                    state_d   = S_DATA;
                end else if (wait_cnt_q == 16'(TOKEN_TIMEOUT - 1)) begin
                    cs_n_d    = 1'b1;
                    bit_cnt_d = '0;
                    rd_err_d  = 1'b1;
                    state_d   = S_END;
                end else begin
                    wait_cnt_d = wait_cnt_q + 16'd1;
                end
            end

            S_DATA: begin
                data_sr_d = word_c[WORD_W-2:0];
                if (bit_cnt_q[3:0] == 4'hF) begin
                    rd_data_d    = word_c;
                    rd_data_en_d = 1'b1;
                end
                if (bit_cnt_q == 12'hFFF) begin
                    bit_cnt_d = '0;
                    state_d   = S_CRC;
                end else begin
                    bit_cnt_d = bit_cnt_q + 12'd1;
                end
            end

            S_CRC: begin
                if (bit_cnt_q == 12'd15) begin
                    cs_n_d    = 1'b1;
                    bit_cnt_d = '0;
                    state_d   = S_END;
                end else begin
                    bit_cnt_d = bit_cnt_q + 12'd1;
                end
            end

            // Deselected idle clocks so the card lets go of miso.
            S_END: begin
                cs_n_d = 1'b1;
                mosi_d = 1'b1;
                if (bit_cnt_q == 12'd7) begin
                    busy_d  = 1'b0;
                    state_d = S_IDLE;
                end else begin
                    bit_cnt_d = bit_cnt_q + 12'd1;
                end
            end

            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    assign sd.cs_n       = cs_n_q;
    assign sd.mosi       = mosi_q;
    assign sd.rd_busy    = busy_q;
    assign sd.rd_data    = rd_data_q;
    assign sd.rd_data_en = rd_data_en_q;
    assign sd.rd_err     = rd_err_q;
endmodule

// File: tb/tb_sd_spi_block_read.sv
// Bench for sd_spi_block_read: behavioural SPI card plus scoreboards for command bytes and payload words.
module tb_sd_spi_block_read;
    logic clk = 1'b0;
    logic rst;

    sd_spi_block_read_if sd ();

    sd_spi_block_read #(
        .CMD_IDX       (8'h51),
        .R1_TIMEOUT    (64),
        .TOKEN_TIMEOUT (65535)
    ) dut (
        .sys_clk (clk),
        .sys_rst (rst),
        .sd      (sd)
    );

    always #5 clk = ~clk;

    int pass_cnt  = 0;
    int total_cnt = 0;

    logic [15:0] exp_words[$];
    logic [7:0]  exp_cmd[$];
    bit          resp_q[$];

    int          cyc = 0;
    int          strobe_cnt = 0;
    int          err_cnt = 0;
    int          err_cyc = 0;
    int          lastbit_cyc = 0;
    int          card_mode = 0;   // 0 normal, 1 silent after command, 2 R1 but never a token
    logic [7:0]  card_r1 = 8'h00;
    logic [47:0] frame = '0;
    int          nbits = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total_cnt++;
        assert (obs === exp) begin
            pass_cnt++;
        end else begin
            $error("FAIL %s: observed 0x%0h required 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(negedge clk);
        #1;
    endtask

    task automatic push_byte(input logic [7:0] b);
        for (int i = 7; i >= 0; i--) resp_q.push_back(b[i]);
    endtask

    task automatic push_cmd(input logic [31:0] addr);
        exp_cmd.push_back(8'h51);
        exp_cmd.push_back(addr[31:24]);
        exp_cmd.push_back(addr[23:16]);
        exp_cmd.push_back(addr[15:8]);
        exp_cmd.push_back(addr[7:0]);
        exp_cmd.push_back(8'hFF);
    endtask

    task automatic push_words();
        for (int n = 0; n < 256; n++) exp_words.push_back({8'(2 * n), 8'(2 * n + 1)});
    endtask

    // Compare a received command frame against the scoreboard, then schedule the card's answer.
    task automatic frame_done();
        logic [7:0] eb;
        check("cmd_queue_depth", 32'(exp_cmd.size() >= 6), 32'd1);
        for (int k = 0; k < 6; k++) begin
            if (exp_cmd.size() > 0) begin
                eb = exp_cmd.pop_front();
                check($sformatf("cmd_byte%0d", k), 32'(frame[47 - 8 * k -: 8]), 32'(eb));
            end
        end
        if (card_mode != 1) begin
            for (int i = 0; i < 3; i++) push_byte(8'hFF);
            push_byte(card_r1);
            if (card_mode == 0 && card_r1 == 8'h00) begin
                for (int i = 0; i < 10; i++) push_byte(8'hFF);
                push_byte(8'hFE);
                for (int i = 0; i < 512; i++) push_byte(8'(i));
                push_byte(8'hA5);
                push_byte(8'h5A);
            end
        end
    endtask

    always @(posedge clk) cyc++;

    // Card: captures mosi and drives miso on the falling edge, away from the DUT's sampling edge.
    always @(negedge clk) begin
        if (sd.cs_n !== 1'b0) begin
            nbits = 0;
            resp_q.delete();
            sd.miso = 1'b1;
        end else begin
            if (resp_q.size() > 0) sd.miso = resp_q.pop_front();
            else                   sd.miso = 1'b1;
            if (nbits < 48) begin
                frame = {frame[46:0], sd.mosi};
                nbits++;
                if (nbits == 48) begin
                    lastbit_cyc = cyc;
                    frame_done();
                end
            end
        end
    end

    // Payload scoreboard.
    always @(negedge clk) begin
        if (sd.rd_data_en === 1'b1) begin
            strobe_cnt++;
            check("strobe_expected", 32'(exp_words.size() > 0), 32'd1);
            if (exp_words.size() > 0) check("word", 32'(sd.rd_data), 32'(exp_words.pop_front()));
        end
    end

    always @(negedge clk) begin
        if (sd.rd_err === 1'b1) begin
            err_cnt++;
            err_cyc = cyc;
        end
    end

    task automatic start_read(input logic [31:0] addr, input string tag);
        sd.rd_addr = addr;
        sd.rd_en   = 1'b1;
        tick();
        sd.rd_en   = 1'b0;
        check({tag, "_busy"}, 32'(sd.rd_busy), 32'd1);
        check({tag, "_cs_n"}, 32'(sd.cs_n), 32'd0);
        check({tag, "_mosi0"}, 32'(sd.mosi), 32'd0);
    endtask

    task automatic wait_idle(input int budget, input string tag);
        int n = 0;
        while (sd.rd_busy === 1'b1 && n < budget) begin
            tick();
            n++;
        end
        check(tag, 32'(sd.rd_busy), 32'd0);
    endtask

    task automatic wait_strobes(input int target, input int budget, input string tag);
        int n = 0;
        while (strobe_cnt < target && n < budget) begin
            tick();
            n++;
        end
        check(tag, 32'(strobe_cnt >= target), 32'd1);
    endtask

    task automatic wait_err(input int budget, input string tag);
        int n = 0;
        while (err_cnt == 0 && n < budget) begin
            tick();
            n++;
        end
        check(tag, 32'(err_cnt), 32'd1);
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_cs_n"},  32'(sd.cs_n), 32'd1);
        check({tag, "_mosi"},  32'(sd.mosi), 32'd1);
        check({tag, "_busy"},  32'(sd.rd_busy), 32'd0);
        check({tag, "_en"},    32'(sd.rd_data_en), 32'd0);
        check({tag, "_data"},  32'(sd.rd_data), 32'd0);
        check({tag, "_err"},   32'(sd.rd_err), 32'd0);
    endtask

    initial begin
        int delta;
        rst        = 1'b1;
        sd.rd_en   = 1'b0;
        sd.rd_addr = '0;
        repeat (3) tick();
        check_reset_outputs("reset");
        rst = 1'b0;
        tick();

        // Good read, with a request arriving mid-payload that must be ignored.
        push_cmd(32'h0000_1234);
        push_words();
        card_mode = 0;
        card_r1 = 8'h00;
        strobe_cnt = 0;
        err_cnt = 0;
        start_read(32'h0000_1234, "rdA");
        wait_strobes(50, 2000, "rdA_progress");
        sd.rd_addr = 32'hDEAD_BEEF;
        sd.rd_en   = 1'b1;
        tick();
        sd.rd_en   = 1'b0;
        wait_idle(6000, "rdA_done");
        check("rdA_strobes", 32'(strobe_cnt), 32'd256);
        check("rdA_err", 32'(err_cnt), 32'd0);
        check("rdA_words_left", 32'(exp_words.size()), 32'd0);
        check("rdA_data_hold", 32'(sd.rd_data), 32'h0000_FEFF);

        // Request in the first idle cycle; card answers R1=0x05.
        push_cmd(32'h0000_ABCD);
        card_r1 = 8'h05;
        strobe_cnt = 0;
        err_cnt = 0;
        start_read(32'h0000_ABCD, "rdB");
        wait_err(200, "r1err_seen");
        check("r1err_end_cs_n", 32'(sd.cs_n), 32'd1);
        check("r1err_end_busy", 32'(sd.rd_busy), 32'd1);
        for (int i = 1; i < 8; i++) begin
            tick();
            check($sformatf("r1err_end%0d", i), 32'({sd.cs_n, sd.rd_busy, sd.rd_err}), 32'b110);
        end
        tick();
        check("r1err_busy_fall", 32'(sd.rd_busy), 32'd0);
        check("r1err_pulses", 32'(err_cnt), 32'd1);
        check("r1err_strobes", 32'(strobe_cnt), 32'd0);

        // Card silent after the command: R1 timeout.
        push_cmd(32'hFFFF_0000);
        card_mode = 1;
        card_r1 = 8'h00;
        strobe_cnt = 0;
        err_cnt = 0;
        start_read(32'hFFFF_0000, "rdC");
        wait_err(200, "r1to_seen");
        delta = err_cyc - lastbit_cyc;
        check("r1to_delay_window", 32'(delta >= 64 && delta <= 65), 32'd1);
        wait_idle(20, "r1to_done");
        check("r1to_strobes", 32'(strobe_cnt), 32'd0);
        check("r1to_pulses", 32'(err_cnt), 32'd1);

        // R1 ok but no token: token timeout (3 idle bytes + R1 precede the token wait).
        push_cmd(32'h0000_0007);
        card_mode = 2;
        strobe_cnt = 0;
        err_cnt = 0;
        start_read(32'h0000_0007, "rdD");
        wait_err(70000, "tokto_seen");
        delta = err_cyc - lastbit_cyc;
        check("tokto_delay_window", 32'(delta >= 65535 + 30 && delta <= 65535 + 36), 32'd1);
        wait_idle(20, "tokto_done");
        check("tokto_strobes", 32'(strobe_cnt), 32'd0);
        check("tokto_pulses", 32'(err_cnt), 32'd1);

        // Reset right after strobe 100.
        push_cmd(32'h0000_0042);
        push_words();
        card_mode = 0;
        strobe_cnt = 0;
        err_cnt = 0;
        start_read(32'h0000_0042, "rdE");
        wait_strobes(100, 3000, "rdE_progress");
        rst = 1'b1;
        #1;
        check_reset_outputs("midrst");
        exp_words.delete();
        repeat (3) tick();
        rst = 1'b0;
        repeat (50) tick();
        check("midrst_strobes", 32'(strobe_cnt), 32'd100);
        check("midrst_err", 32'(err_cnt), 32'd0);

        // Full read after the abort.
        push_cmd(32'h0001_0000);
        push_words();
        strobe_cnt = 0;
        start_read(32'h0001_0000, "rdF");
        wait_idle(6000, "rdF_done");
        check("rdF_strobes", 32'(strobe_cnt), 32'd256);
        check("rdF_err", 32'(err_cnt), 32'd0);
        check("rdF_words_left", 32'(exp_words.size()), 32'd0);
        check("cmd_left", 32'(exp_cmd.size()), 32'd0);

        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end
endmodule
